// File: rtl/matmul_sp_bank.sv
// ---------------------------------------------------------------------------
// matmul_sp_bank
//   Multi-slot result scratchpad for the matmul accelerator. SP_NTARGETS
//   slots, each holding a MAX_DIM x MAX_DIM matrix (N_EL elements) of
//   BUS_WIDTH bits, stored row-major.
//
//   Host port   : single-element read (1-cycle latency) / write, with an error
//                 pulse for out-of-range slots or writes to the slot currently
//                 owned by the engine.
//   Engine port : start pulse selects slot and mode, then a row-major stream of
//                 N_EL elements either overwrites the slot or accumulates into
//                 it (C = C + A*B). One element per cycle, no stall.
//
//   Optional feature macro: SP_SAT_EN
//     defined     -> accumulate is signed saturating, clamps set sticky e_ovf_o
//     not defined -> wrap-around accumulate, e_ovf_o tied low
//
// Ports
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   h_req_i, h_we_i, h_slot_i, h_idx_i  host request / write enable / address
//   h_wdata_i                           host write data
//   h_rdata_o, h_rvalid_o               host read data and its valid pulse
//   h_err_o                             host error pulse
//   e_start_i, e_slot_i, e_acc_i        engine start, target slot, accumulate
//   e_valid_i, e_data_i, e_ready_o      engine stream handshake
//   e_busy_o, e_done_o, e_ovf_o         engine status
//   slot_valid_o                        per-slot "contains data" flags
// ---------------------------------------------------------------------------
module matmul_sp_bank #(
  parameter  int BUS_WIDTH   = 64,
  parameter  int SP_NTARGETS = 4,
  parameter  int MAX_DIM     = 4,
  localparam int N_EL        = MAX_DIM * MAX_DIM,
  localparam int SW          = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
  localparam int IW          = (N_EL > 1) ? $clog2(N_EL) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   h_req_i,
  input  logic                   h_we_i,
  input  logic [SW-1:0]          h_slot_i,
  input  logic [IW-1:0]          h_idx_i,
  input  logic [BUS_WIDTH-1:0]   h_wdata_i,
  output logic [BUS_WIDTH-1:0]   h_rdata_o,
  output logic                   h_rvalid_o,
  output logic                   h_err_o,
  input  logic                   e_start_i,
  input  logic [SW-1:0]          e_slot_i,
  input  logic                   e_acc_i,
  input  logic                   e_valid_i,
  input  logic [BUS_WIDTH-1:0]   e_data_i,
  output logic                   e_ready_o,
  output logic                   e_busy_o,
  output logic                   e_done_o,
  output logic                   e_ovf_o,
  output logic [SP_NTARGETS-1:0] slot_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Engine session context captured at start
  logic [SW-1:0]          r_eslot;
  logic                   r_eacc;
  logic [IW-1:0]          r_cnt;

  logic [SP_NTARGETS-1:0] r_slot_valid;
  logic [BUS_WIDTH-1:0]   r_mem [SP_NTARGETS][N_EL];

  logic [BUS_WIDTH-1:0]   r_rdata;
  logic                   r_rvalid;
  logic                   r_err;
  logic                   r_e_ready;
  logic                   r_e_busy;
  logic                   r_e_done;

  logic                   w_h_slot_ok;
  logic                   w_e_slot_ok;
  logic                   w_start_acc;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_h_rd;
  logic                   w_h_conflict;
  logic                   w_h_wr;
  logic                   w_h_err;
  logic [BUS_WIDTH-1:0]   w_old;
  logic [BUS_WIDTH-1:0]   w_e_wdata;

`ifdef SP_SAT_EN
  logic                   w_clamp;
  logic                   r_ovf;

  // Signed saturating add; bit [BUS_WIDTH] of the result flags a clamp.
  // Overflow is only possible when both operands share a sign and the
  // wrapped sum's sign differs from it.
  function automatic logic [BUS_WIDTH:0] sat_add(input logic [BUS_WIDTH-1:0] a,
                                                 input logic [BUS_WIDTH-1:0] b);
    logic [BUS_WIDTH-1:0] sum;
    logic [BUS_WIDTH:0]   res;
    sum = a + b;
    if ((a[BUS_WIDTH-1] == b[BUS_WIDTH-1]) && (sum[BUS_WIDTH-1] != a[BUS_WIDTH-1])) begin
      if (a[BUS_WIDTH-1]) begin
        res = {1'b1, 1'b1, {(BUS_WIDTH-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(BUS_WIDTH-1){1'b1}}};
      end
    end else begin
      res = {1'b0, sum};
    end
    return res;
  endfunction
`endif

  // Request qualification: range checks, handshakes and host/engine arbitration
  always_comb begin
    w_h_slot_ok  = (32'(h_slot_i) < SP_NTARGETS);
    w_e_slot_ok  = (32'(e_slot_i) < SP_NTARGETS);
    w_start_acc  = (r_state == ST_IDLE) && e_start_i && w_e_slot_ok;
    w_xfer       = (r_state == ST_STREAM) && e_valid_i;
    w_last       = w_xfer && (r_cnt == IW'(N_EL - 1));
    w_h_rd       = h_req_i && !h_we_i;
    // Engine owns its slot from start through the DONE cycle
    w_h_conflict = (r_state != ST_IDLE) && (h_slot_i == r_eslot);
    w_h_wr       = h_req_i && h_we_i && w_h_slot_ok && !w_h_conflict;
    w_h_err      = h_req_i && (!w_h_slot_ok || (h_we_i && w_h_conflict));
  end

  // Engine write data: overwrite, or read-modify-write against the current slot content
  always_comb begin
    w_old     = '0;
    w_e_wdata = e_data_i;
`ifdef SP_SAT_EN
    w_clamp   = 1'b0;
`endif
    // A slot that never held data accumulates from zero
    if (r_slot_valid[r_eslot]) begin
      w_old = r_mem[r_eslot][r_cnt];
    end else begin
      w_old = '0;
    end
    if (r_eacc) begin
`ifdef SP_SAT_EN
      {w_clamp, w_e_wdata} = sat_add(w_old, e_data_i);
`else
      w_e_wdata = w_old + e_data_i;
`endif
    end else begin
      w_e_wdata = e_data_i;
    end
  end

  // Next-state logic for the engine session
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, engine context, status flags and host response registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_eslot      <= '0;
      r_eacc       <= 1'b0;
      r_cnt        <= '0;
      r_slot_valid <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
      r_e_ready    <= 1'b0;
      r_e_busy     <= 1'b0;
      r_e_done     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Status outputs are registered from the next state so they line up with it
      r_e_ready <= (w_state_nxt == ST_STREAM);
      r_e_busy  <= (w_state_nxt != ST_IDLE);
      r_e_done  <= (w_state_nxt == ST_DONE);

      if (w_start_acc) begin
        r_eslot <= e_slot_i;
        r_eacc  <= e_acc_i;
        r_cnt   <= '0;
      end else if (w_xfer) begin
        if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + IW'(1);
        end
      end

      if (w_h_wr) begin
        r_slot_valid[h_slot_i] <= 1'b1;
      end
      // Engine slot becomes valid on the same edge as its last element write
      if (w_last) begin
        r_slot_valid[r_eslot] <= 1'b1;
      end

      r_rvalid <= w_h_rd || (h_req_i && !w_h_slot_ok);
      r_err    <= w_h_err;
      // Read data holds between reads; sampled before any same-edge write lands
      if (h_req_i && !w_h_slot_ok) begin
        r_rdata <= '0;
      end else if (w_h_rd) begin
        r_rdata <= r_mem[h_slot_i][h_idx_i];
      end
    end
  end

  // Slot storage: host and engine writes to different slots commit together
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SP_NTARGETS; s++) begin
        for (int i = 0; i < N_EL; i++) begin
          r_mem[s][i] <= '0;
        end
      end
    end else begin
      if (w_h_wr) begin
        r_mem[h_slot_i][h_idx_i] <= h_wdata_i;
      end
      if (w_xfer) begin
        r_mem[r_eslot][r_cnt] <= w_e_wdata;
      end
    end
  end

`ifdef SP_SAT_EN
  // Sticky overflow: cleared by an accepted start, set by any clamp
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (w_start_acc) begin
      r_ovf <= 1'b0;
    end else if (w_xfer && w_clamp) begin
      r_ovf <= 1'b1;
    end
  end

  assign e_ovf_o = r_ovf;
`else
  assign e_ovf_o = 1'b0;
`endif

  assign h_rdata_o    = r_rdata;
  assign h_rvalid_o   = r_rvalid;
  assign h_err_o      = r_err;
  assign e_ready_o    = r_e_ready;
  assign e_busy_o     = r_e_busy;
  assign e_done_o     = r_e_done;
  assign slot_valid_o = r_slot_valid;

endmodule

// File: tb/tb_matmul_sp_bank.sv
// ---------------------------------------------------------------------------
// tb_matmul_sp_bank
//   Self-checking bench for matmul_sp_bank with default parameters
//   (64-bit elements, 4 slots, 4x4 matrices). A transaction-level model of the
//   scratchpad (plain arrays plus an element counter) predicts every output;
//   a negedge process compares all outputs each cycle, and directed scenarios
//   add literal expectations. Honours SP_SAT_EN like the design.
// ---------------------------------------------------------------------------
module tb_matmul_sp_bank;

  localparam int NT   = 4;
  localparam int N_EL = 16;

  logic        clk;
  logic        rst_n;
  logic        h_req_i, h_we_i;
  logic [1:0]  h_slot_i;
  logic [3:0]  h_idx_i;
  logic [63:0] h_wdata_i;
  logic [63:0] h_rdata_o;
  logic        h_rvalid_o, h_err_o;
  logic        e_start_i;
  logic [1:0]  e_slot_i;
  logic        e_acc_i, e_valid_i;
  logic [63:0] e_data_i;
  logic        e_ready_o, e_busy_o, e_done_o, e_ovf_o;
  logic [3:0]  slot_valid_o;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [63:0] m_mem [NT][N_EL];
  logic [3:0]  m_valid;
  bit          m_busy, m_done, m_eacc, m_ovf;
  int          m_cnt, m_eslot;
  logic [63:0] m_rdata;
  bit          m_rvalid, m_err;

  // Expected outputs after the most recent edge
  logic [63:0] exp_rdata;
  bit          exp_rvalid, exp_err, exp_ready, exp_busy, exp_done, exp_ovf;
  logic [3:0]  exp_sv;

  matmul_sp_bank dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .h_req_i     (h_req_i),
    .h_we_i      (h_we_i),
    .h_slot_i    (h_slot_i),
    .h_idx_i     (h_idx_i),
    .h_wdata_i   (h_wdata_i),
    .h_rdata_o   (h_rdata_o),
    .h_rvalid_o  (h_rvalid_o),
    .h_err_o     (h_err_o),
    .e_start_i   (e_start_i),
    .e_slot_i    (e_slot_i),
    .e_acc_i     (e_acc_i),
    .e_valid_i   (e_valid_i),
    .e_data_i    (e_data_i),
    .e_ready_o   (e_ready_o),
    .e_busy_o    (e_busy_o),
    .e_done_o    (e_done_o),
    .e_ovf_o     (e_ovf_o),
    .slot_valid_o(slot_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, expv);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    logic [63:0] old_v;
    logic [63:0] new_v;
`ifdef SP_SAT_EN
    logic signed [64:0] wide;
`endif
    if (!rst_n) begin
      foreach (m_mem[s, i]) m_mem[s][i] = 64'd0;
      m_valid = 4'd0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_eslot = 0;
      m_eacc = 1'b0; m_ovf = 1'b0; m_rdata = 64'd0; m_rvalid = 1'b0; m_err = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      if (h_req_i) begin
        if (!h_we_i) begin
          m_rvalid = 1'b1;
          m_rdata  = m_mem[h_slot_i][h_idx_i];
        end else if (m_busy && (int'(h_slot_i) == m_eslot)) begin
          m_err = 1'b1;
        end else begin
          m_mem[h_slot_i][h_idx_i] = h_wdata_i;
          m_valid[h_slot_i] = 1'b1;
        end
      end
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (e_valid_i) begin
          old_v = m_valid[m_eslot] ? m_mem[m_eslot][m_cnt] : 64'd0;
          if (!m_eacc) begin
            new_v = e_data_i;
          end else begin
`ifdef SP_SAT_EN
            wide = $signed({old_v[63], old_v}) + $signed({e_data_i[63], e_data_i});
            if (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) begin
              new_v = 64'h7FFF_FFFF_FFFF_FFFF; m_ovf = 1'b1;
            end else if (wide < 65'sh1_8000_0000_0000_0000) begin
              new_v = 64'h8000_0000_0000_0000; m_ovf = 1'b1;
            end else begin
              new_v = wide[63:0];
            end
`else
            new_v = old_v + e_data_i;
`endif
          end
          m_mem[m_eslot][m_cnt] = new_v;
          m_cnt++;
          if (m_cnt == N_EL) begin
            m_cnt  = 0;
            m_done = 1'b1;
            m_valid[m_eslot] = 1'b1;
          end
        end
      end else if (e_start_i) begin
        m_busy  = 1'b1;
        m_eslot = int'(e_slot_i);
        m_eacc  = e_acc_i;
        m_cnt   = 0;
        m_ovf   = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    exp_rdata  = m_rdata;
    exp_rvalid = m_rvalid;
    exp_err    = m_err;
    exp_ready  = m_busy && !m_done;
    exp_busy   = m_busy;
    exp_done   = m_done;
    exp_sv     = m_valid;
`ifdef SP_SAT_EN
    exp_ovf    = m_ovf;
`else
    exp_ovf    = 1'b0;
`endif
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("h_rdata",    h_rdata_o,           exp_rdata);
      check("h_rvalid",   64'(h_rvalid_o),     64'(exp_rvalid));
      check("h_err",      64'(h_err_o),        64'(exp_err));
      check("e_ready",    64'(e_ready_o),      64'(exp_ready));
      check("e_busy",     64'(e_busy_o),       64'(exp_busy));
      check("e_done",     64'(e_done_o),       64'(exp_done));
      check("e_ovf",      64'(e_ovf_o),        64'(exp_ovf));
      check("slot_valid", 64'(slot_valid_o),   64'(exp_sv));
    end
  end

  task automatic idle_inputs();
    h_req_i = 1'b0; h_we_i = 1'b0; h_slot_i = 2'd0; h_idx_i = 4'd0; h_wdata_i = 64'd0;
    e_start_i = 1'b0; e_slot_i = 2'd0; e_acc_i = 1'b0; e_valid_i = 1'b0; e_data_i = 64'd0;
  endtask

  task automatic host_write(input int s, input int i, input logic [63:0] d);
    h_req_i = 1'b1; h_we_i = 1'b1; h_slot_i = 2'(s); h_idx_i = 4'(i); h_wdata_i = d;
    tick();
    h_req_i = 1'b0; h_we_i = 1'b0;
  endtask

  task automatic host_read(input string nm, input int s, input int i, input logic [63:0] expv);
    h_req_i = 1'b1; h_we_i = 1'b0; h_slot_i = 2'(s); h_idx_i = 4'(i);
    tick();
    h_req_i = 1'b0;
    check(nm, h_rdata_o, expv);
  endtask

  task automatic start(input int s, input bit acc);
    e_start_i = 1'b1; e_slot_i = 2'(s); e_acc_i = acc;
    tick();
    e_start_i = 1'b0;
  endtask

  task automatic push(input logic [63:0] d, input bit gaps);
    if (gaps) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end
    e_valid_i = 1'b1; e_data_i = d;
    tick();
    e_valid_i = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    h_req_i = 1'($urandom); h_we_i = 1'($urandom); h_slot_i = 2'($urandom); h_idx_i = 4'($urandom);
    h_wdata_i = {$urandom, $urandom}; e_start_i = 1'($urandom); e_slot_i = 2'($urandom);
    e_acc_i = 1'($urandom); e_valid_i = 1'($urandom); e_data_i = {$urandom, $urandom};
    tick();
    chk_on = 1'b1;
    tick();
    check("rst_slot_valid", 64'(slot_valid_o), 64'd0);
    rst_n = 1'b1;
    idle_inputs();
    host_read("rst_read_s0i0", 0, 0, 64'd0);

    // Overwrite slot 2 with 1..16, gapped stream
    start(2, 1'b0);
    for (int k = 1; k <= N_EL; k++) push(64'(k), 1'b1);
    check("ovw_done", 64'(e_done_o), 64'd1);
    tick();
    check("ovw_slot_valid", 64'(slot_valid_o), 64'h4);
    host_read("ovw_s2i5", 2, 5, 64'd6);

    // Accumulate 5 onto a slot of 100s, then onto the never-written slot 3
    for (int i = 0; i < N_EL; i++) host_write(1, i, 64'd100);
    start(1, 1'b1);
    for (int k = 0; k < N_EL; k++) push(64'd5, 1'b0);
    tick();
    for (int i = 0; i < N_EL; i++) host_read("acc_s1", 1, i, 64'd105);
    start(3, 1'b1);
    for (int k = 0; k < N_EL; k++) push(64'd5, 1'b0);
    tick();
    for (int i = 0; i < N_EL; i += 5) host_read("acc_s3", 3, i, 64'd5);

    // Host/engine conflicts and ignored mid-stream start
    start(0, 1'b0);
    push(64'd200, 1'b0);
    push(64'd201, 1'b0);
    host_write(0, 0, 64'hDEAD);
    check("conf_err", 64'(h_err_o), 64'd1);
    h_req_i = 1'b1; h_we_i = 1'b1; h_slot_i = 2'd1; h_idx_i = 4'd3; h_wdata_i = 64'hAA;
    e_start_i = 1'b1; e_slot_i = 2'd3; e_acc_i = 1'b1;
    push(64'd202, 1'b0);
    idle_inputs();
    check("conf_other_err", 64'(h_err_o), 64'd0);
    for (int k = 3; k < N_EL; k++) push(64'(200 + k), 1'b0);
    tick();
    host_read("conf_s0i0", 0, 0, 64'd200);
    host_read("conf_s0i2", 0, 2, 64'd202);
    host_read("conf_s1i3", 1, 3, 64'hAA);
    host_read("conf_s3i1", 3, 1, 64'd5);

    // Overflow on accumulate
    host_write(0, 0, 64'h7FFF_FFFF_FFFF_FFFF);
    start(0, 1'b1);
    push(64'd1, 1'b0);
    for (int k = 1; k < N_EL; k++) push(64'd0, 1'b0);
    tick();
`ifdef SP_SAT_EN
    check("ovf_flag", 64'(e_ovf_o), 64'd1);
    host_read("ovf_s0i0", 0, 0, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    check("ovf_flag", 64'(e_ovf_o), 64'd0);
    host_read("ovf_s0i0", 0, 0, 64'h8000_0000_0000_0000);
`endif

    // Reset part-way through a stream
    start(1, 1'b0);
    for (int k = 0; k < 7; k++) push(64'(50 + k), 1'b0);
    rst_n = 1'b0;
    tick();
    check("rst_mid_done", 64'(e_done_o), 64'd0);
    check("rst_mid_sv", 64'(slot_valid_o), 64'd0);
    rst_n = 1'b1;
    start(1, 1'b0);
    for (int k = 0; k < N_EL; k++) push(64'(300 + k), 1'b0);
    check("rst_mid_done2", 64'(e_done_o), 64'd1);
    tick();
    host_read("rst_mid_s1i0", 1, 0, 64'd300);
    host_read("rst_mid_s1i7", 1, 7, 64'd307);

    // Randomized traffic on both ports
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      h_req_i   = ($urandom_range(0, 1) != 0);
      h_we_i    = ($urandom_range(0, 2) == 0);
      h_slot_i  = 2'($urandom);
      h_idx_i   = 4'($urandom);
      h_wdata_i = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
      e_start_i = ($urandom_range(0, 7) == 0);
      e_slot_i  = 2'($urandom);
      e_acc_i   = 1'($urandom);
      e_valid_i = ($urandom_range(0, 9) < 7);
      e_data_i  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
